// File: rtl/hword_lsu.sv
// Load/store sequencer between a CPU data-access port and a half-word RAM port.
// Byte/half/word accesses are split into 1-3 legal RAM beats; loads are merged and extended.
module hword_lsu #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic [1:0]            mem_wenable,
    input  logic [15:0]           mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse with no back-pressure.
    logic [1:0]            state_q;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           asm_q;
    logic [1:0]            ptr_q;

    logic [2:0]            total;
    logic [2:0]            remain;
    logic [2:0]            beat_bytes;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  beat_half;
    logic                  beat_last;
    logic                  in_beat;
    logic [31:0]           wshift;
    logic [15:0]           rdata_m;
    logic [31:0]           ins;
    logic [31:0]           ext;

    // ptr_q counts bytes already transferred; a beat is a half only when it is
    // even-aligned and at least two bytes remain, which yields every legal plan.
    always_comb begin
        case (size_q)
            2'b00:   total = 3'd1;
            2'b01:   total = 3'd2;
            default: total = 3'd4;
        endcase
        remain     = total - {1'b0, ptr_q};
        beat_addr  = addr_q + ADDR_WIDTH'(ptr_q);
        beat_half  = !beat_addr[0] && (remain >= 3'd2);
        beat_bytes = beat_half ? 3'd2 : 3'd1;
        beat_last  = (remain == beat_bytes);
        wshift     = wdata_q >> {ptr_q, 3'b000};
        rdata_m    = beat_half ? mem_rdata : {8'h00, mem_rdata[7:0]};
        ins        = {16'h0000, rdata_m} << {ptr_q, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{signed_q & asm_q[7]}}, asm_q[7:0]};
            2'b01:   ext = {{16{signed_q & asm_q[15]}}, asm_q[15:0]};
            default: ext = asm_q;
        endcase
    end

    assign in_beat     = (state_q == S_BEAT);
    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_error  = resp_valid && error_q;
    assign resp_rdata  = (resp_valid && !write_q && !error_q) ? ext : 32'h0;
    assign mem_addr    = in_beat ? beat_addr : '0;
    assign mem_wenable = (in_beat && write_q) ? (beat_half ? 2'b11 : 2'b01) : 2'b00;
    assign mem_wdata   = (in_beat && write_q) ? (beat_half ? wshift[15:0] : {8'h00, wshift[7:0]})
                                              : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            error_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            asm_q    <= 32'h0;
            ptr_q    <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        asm_q    <= 32'h0;
                        ptr_q    <= 2'd0;
                        error_q  <= (req_size == 2'b11);
                        state_q  <= (req_size == 2'b11) ? S_RESP : S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (!write_q) asm_q <= asm_q | ins;
                    if (beat_last) state_q <= S_RESP;
                    else           ptr_q   <= ptr_q + beat_bytes[1:0];
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hword_lsu.sv
// Bench for hword_lsu: byte-array RAM model, driver task with inline beat checks,
// and a response monitor popping an expected queue.
module tb_hword_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_wenable;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // {response cycle[31:0], error, rdata[31:0]}
    logic [64:0] exp_q[$];
    logic [7:0]  ram [0:65535];

    hword_lsu #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wenable(mem_wenable), .mem_rdata(mem_rdata)
    );

    // clock / reset / RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem_addr[0] ? {8'h00, ram[mem_addr]} : {ram[mem_addr | 16'h0001], ram[mem_addr]};

    always @(posedge clk) begin
        if (mem_wenable[0]) ram[mem_addr] <= mem_wdata[7:0];
        if (mem_wenable[1]) ram[mem_addr + 16'd1] <= mem_wdata[15:8];
    end

    // response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wenable[1] && mem_addr[0]) begin
                tests++; fails++;
                $display("FAIL odd_half_we addr=%h we=%b", mem_addr, mem_wenable);
            end
            if (resp_valid) begin
                logic [64:0] e;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp cyc=%0d err=%b rdata=%h", cyc, resp_error, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== int'(e[64:33]) || resp_error !== e[32] || resp_rdata !== e[31:0]) begin
                        fails++;
                        $display("FAIL resp got cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h",
                                 cyc, resp_error, resp_rdata, e[64:33], e[32], e[31:0]);
                    end
                end
                tests++;
                if (mem_wenable !== 2'b00) begin
                    fails++;
                    $display("FAIL resp_we got %b expected 00", mem_wenable);
                end
            end
        end
    end

    function automatic logic [33:0] bt(input logic [15:0] a, input logic [1:0] we, input logic [15:0] d);
        return {a, we, d};
    endfunction

    // driver: issue one request, check its beats, optionally queue its response
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [15:0] a,
                         input logic [31:0] wd, input int nb, input logic [33:0] b0, input logic [33:0] b1,
                         input logic [33:0] b2, input logic [31:0] exp_rd, input logic exp_err,
                         input bit want_resp, output int acc);
        logic [33:0] bl [3];
        int budget;
        bl[0] = b0; bl[1] = b1; bl[2] = b2;
        acc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout addr=%h ready=%b expected 1", a, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = 16'($urandom);
        req_wdata  = $urandom;
        if (want_resp) exp_q.push_back({32'(acc + nb), exp_err, exp_rd});
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            tests++;
            if (mem_addr !== bl[i][33:18] || mem_wenable !== bl[i][17:16] ||
                (bl[i][17:16] != 2'b00 && mem_wdata !== bl[i][15:0])) begin
                fails++;
                $display("FAIL beat%0d@%h got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                         i, a, mem_addr, mem_wenable, mem_wdata, bl[i][33:18], bl[i][17:16], bl[i][15:0]);
            end
        end
    endtask

    task automatic wait_done();
        int b = 0;
        while (exp_q.size() != 0 && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL resp_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_ram(input logic [15:0] a, input logic [7:0] v);
        tests++;
        if (ram[a] !== v) begin
            fails++;
            $display("FAIL ram[%h] got %h expected %h", a, ram[a], v);
        end
    endtask

    task automatic chk_idle(input string tag);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_wenable !== 2'b00) begin
            fails++;
            $display("FAIL %s got rdy=%b rv=%b re=%b rd=%h ma=%h wd=%h we=%b expected 1,0,0,0,0,0,0",
                     tag, req_ready, resp_valid, resp_error, resp_rdata, mem_addr, mem_wdata, mem_wenable);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset_state");

        // store word, even address
        issue(1, 2'b10, 0, 16'h0010, 32'hDEADBEEF, 2, bt(16'h0010, 2'b11, 16'hBEEF),
              bt(16'h0012, 2'b11, 16'hDEAD), 34'h0, 32'h0, 0, 1, a1);
        wait_done();
        chk_ram(16'h0010, 8'hEF); chk_ram(16'h0011, 8'hBE);
        chk_ram(16'h0012, 8'hAD); chk_ram(16'h0013, 8'hDE);

        // load word, odd address
        ram[16'h0011] <= 8'h11; ram[16'h0012] <= 8'h22; ram[16'h0013] <= 8'h33; ram[16'h0014] <= 8'h44;
        issue(0, 2'b10, 0, 16'h0011, 32'h0, 3, bt(16'h0011, 2'b00, 16'h0), bt(16'h0012, 2'b00, 16'h0),
              bt(16'h0014, 2'b00, 16'h0), 32'h44332211, 0, 1, a1);
        wait_done();

        // byte / half extension
        ram[16'h0030] <= 8'h80; ram[16'h0031] <= 8'h01; ram[16'h0032] <= 8'h80;
        issue(0, 2'b00, 1, 16'h0030, 32'h0, 1, bt(16'h0030, 2'b00, 16'h0), 34'h0, 34'h0,
              32'hFFFFFF80, 0, 1, a1);
        wait_done();
        issue(0, 2'b00, 0, 16'h0030, 32'h0, 1, bt(16'h0030, 2'b00, 16'h0), 34'h0, 34'h0,
              32'h00000080, 0, 1, a1);
        wait_done();
        issue(0, 2'b01, 1, 16'h0031, 32'h0, 2, bt(16'h0031, 2'b00, 16'h0), bt(16'h0032, 2'b00, 16'h0),
              34'h0, 32'hFFFF8001, 0, 1, a1);
        wait_done();
        issue(0, 2'b01, 0, 16'h0030, 32'h0, 1, bt(16'h0030, 2'b00, 16'h0), 34'h0, 34'h0,
              32'h00000180, 0, 1, a1);
        wait_done();

        // store half, odd address, read back by bytes
        issue(1, 2'b01, 0, 16'h0021, 32'h0000A55A, 2, bt(16'h0021, 2'b01, 16'h005A),
              bt(16'h0022, 2'b01, 16'h00A5), 34'h0, 32'h0, 0, 1, a1);
        wait_done();
        issue(0, 2'b00, 0, 16'h0021, 32'h0, 1, bt(16'h0021, 2'b00, 16'h0), 34'h0, 34'h0,
              32'h0000005A, 0, 1, a1);
        wait_done();
        issue(0, 2'b00, 1, 16'h0022, 32'h0, 1, bt(16'h0022, 2'b00, 16'h0), 34'h0, 34'h0,
              32'hFFFFFFA5, 0, 1, a1);
        wait_done();

        // store byte takes the low byte only
        issue(1, 2'b00, 0, 16'h0051, 32'h1234567F, 1, bt(16'h0051, 2'b01, 16'h007F), 34'h0, 34'h0,
              32'h0, 0, 1, a1);
        wait_done();
        chk_ram(16'h0051, 8'h7F); chk_ram(16'h0052, 8'h00);

        // store word odd, then load it back
        issue(1, 2'b10, 0, 16'h0061, 32'h11223344, 3, bt(16'h0061, 2'b01, 16'h0044),
              bt(16'h0062, 2'b11, 16'h2233), bt(16'h0064, 2'b01, 16'h0011), 32'h0, 0, 1, a1);
        wait_done();
        issue(0, 2'b10, 0, 16'h0061, 32'h0, 3, bt(16'h0061, 2'b00, 16'h0), bt(16'h0062, 2'b00, 16'h0),
              bt(16'h0064, 2'b00, 16'h0), 32'h11223344, 0, 1, a1);
        wait_done();

        // address wraparound, req_signed ignored for word
        ram[16'hFFFF] <= 8'hA1; ram[16'h0000] <= 8'hB2; ram[16'h0001] <= 8'hC3; ram[16'h0002] <= 8'hD4;
        issue(0, 2'b10, 1, 16'hFFFF, 32'h0, 3, bt(16'hFFFF, 2'b00, 16'h0), bt(16'h0000, 2'b00, 16'h0),
              bt(16'h0002, 2'b00, 16'h0), 32'hD4C3B2A1, 0, 1, a1);
        wait_done();

        // illegal size
        issue(1, 2'b11, 0, 16'h0080, 32'hFFFFFFFF, 0, 34'h0, 34'h0, 34'h0, 32'h0, 1, 1, a1);
        wait_done();
        chk_ram(16'h0080, 8'h00);

        // back-to-back: second request accepted in the cycle after resp_valid
        issue(1, 2'b00, 0, 16'h0070, 32'hAAAAAA5C, 1, bt(16'h0070, 2'b01, 16'h005C), 34'h0, 34'h0,
              32'h0, 0, 1, a1);
        issue(0, 2'b00, 0, 16'h0070, 32'h0, 1, bt(16'h0070, 2'b00, 16'h0), 34'h0, 34'h0,
              32'h0000005C, 0, 1, a2);
        wait_done();
        tests++;
        if (a2 !== a1 + 3) begin
            fails++;
            $display("FAIL throughput accept gap got %0d expected 3", a2 - a1);
        end

        // reset during beat 1 of an odd word store
        ram[16'h0041] <= 8'hAA; ram[16'h0042] <= 8'hAA; ram[16'h0043] <= 8'hAA; ram[16'h0044] <= 8'hAA;
        issue(1, 2'b10, 0, 16'h0041, 32'h11223344, 1, bt(16'h0041, 2'b01, 16'h0044), 34'h0, 34'h0,
              32'h0, 0, 0, a1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_reset_abort");
        chk_ram(16'h0041, 8'h44); chk_ram(16'h0042, 8'hAA);
        chk_ram(16'h0043, 8'hAA); chk_ram(16'h0044, 8'hAA);
        repeat (3) @(negedge clk);
        chk_idle("idle_no_resp");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
